// File: rtl/sfx_arbiter_pkg.sv
// Shared definitions for the sound-effect arbiter: FSM states, id width and
// the per-effect tone table (production values plus a short simulation set).
package sfx_arbiter_pkg;

   localparam int NUM_SFX  = 4;
   localparam int SFX_ID_W = 2;
   localparam int PERIOD_W = 17;
   localparam int DUR_W    = 8;

   typedef enum logic [1:0] {IDLE, PLAY, GAP} sfx_state_t;

   typedef struct packed {
      logic [PERIOD_W-1:0] period;
      logic [DUR_W-1:0]    dur;
   } sfx_entry_t;

   // Entries are listed id3 first so that TABLE[i] addresses effect i.
   localparam sfx_entry_t [NUM_SFX-1:0] PROD_SFX_TABLE = {
      17'd37921,  8'd4,
      17'd50607,  8'd1,
      17'd75843,  8'd2,
      17'd113636, 8'd3
   };

   localparam sfx_entry_t [NUM_SFX-1:0] SIM_SFX_TABLE = {
      17'd4,  8'd1,
      17'd10, 8'd0,
      17'd6,  8'd1,
      17'd8,  8'd2
   };

   // Default table selection; the top exposes this as a parameter so a
   // testbench can switch to the short simulation table.
   localparam bit USE_SIM_TABLE = 1'b0;

   function automatic sfx_entry_t sfx_lookup(input logic [SFX_ID_W-1:0] id,
                                             input bit use_sim);
      return use_sim ? SIM_SFX_TABLE[id] : PROD_SFX_TABLE[id];
   endfunction

   function automatic logic [SFX_ID_W-1:0] top_index(input logic [NUM_SFX-1:0] v);
      logic [SFX_ID_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_SFX; i++) begin
         if (v[i]) idx = SFX_ID_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sfx_arbiter_tone.sv
// Square-wave tone counter: counts 0..period-1 while enabled, high in the
// upper half of each period.
module sfx_tone_gen
   import sfx_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [PERIOD_W-1:0] period,
   input  logic                enable,
   input  logic                clear,
   output logic                wave
);

   logic [PERIOD_W-1:0] cnt_tone;
   logic [PERIOD_W-1:0] cnt_inc;

   assign cnt_inc = cnt_tone + PERIOD_W'(1);

   // Wrap test on the incremented value so a zero period simply holds at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_tone <= '0;
      end else if (clear) begin
         cnt_tone <= '0;
      end else if (enable) begin
         cnt_tone <= (cnt_inc >= period) ? '0 : cnt_inc;
      end
   end

   assign wave = (cnt_tone >= (period >> 1));

endmodule

// File: rtl/sfx_arbiter.sv
// Priority arbiter that lets one-shot sound effects pre-empt background music
// on a single buzzer, with a forced silence gap after each effect.
module sfx_arbiter
   import sfx_arbiter_pkg::*;
#(
   parameter int DUR_UNIT   = 50000,
   parameter int GAP_CYCLES = 1000,
   parameter bit USE_SIM    = USE_SIM_TABLE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SFX-1:0]  sfx_req,
   input  logic                music_beep,
   input  logic                music_en,
   output logic                beep,
   output logic                sfx_busy,
   output logic [SFX_ID_W-1:0] sfx_id,
   output logic [NUM_SFX-1:0]  sfx_grant
);

   localparam int UNIT_W = (DUR_UNIT > 1) ? $clog2(DUR_UNIT) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(DUR_UNIT - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   sfx_state_t          state, state_next;
   logic [NUM_SFX-1:0]  pending, pending_next;
   logic [SFX_ID_W-1:0] id_next, grant_id;
   logic [PERIOD_W-1:0] period, period_next;
   logic [DUR_W-1:0]    dur_left, dur_next;
   logic [UNIT_W-1:0]   cnt_unit, unit_next;
   logic [GAP_W-1:0]    cnt_gap, gap_next;
   logic                beep_next, do_grant, tone_wave;
   sfx_entry_t          entry;

   assign grant_id = top_index(pending);
   assign entry    = sfx_lookup(grant_id, USE_SIM);
   assign sfx_busy = (state != IDLE);

   sfx_tone_gen u_tone (
      .clk    (clk),
      .rst    (rst),
      .period (period),
      .enable (state == PLAY),
      .clear  (do_grant),
      .wave   (tone_wave)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pending  <= '0;
         sfx_id   <= '0;
         period   <= '0;
         dur_left <= '0;
         cnt_unit <= '0;
         cnt_gap  <= '0;
         beep     <= 1'b0;
      end else begin
         state    <= state_next;
         pending  <= pending_next;
         sfx_id   <= id_next;
         period   <= period_next;
         dur_left <= dur_next;
         cnt_unit <= unit_next;
         cnt_gap  <= gap_next;
         beep     <= beep_next;
      end
   end

   // A grant (fresh or pre-empting) overrides the end-of-duration transition.
   always_comb begin
      state_next  = state;
      id_next     = sfx_id;
      period_next = period;
      dur_next    = dur_left;
      unit_next   = cnt_unit;
      gap_next    = cnt_gap;
      do_grant    = 1'b0;
      beep_next   = 1'b0;

      case (state)
         IDLE: begin
            beep_next = music_beep & music_en;
            if (|pending) do_grant = 1'b1;
         end
         PLAY: begin
            beep_next = tone_wave;
            if ((|pending) && (grant_id > sfx_id)) begin
               do_grant = 1'b1;
            end else if (cnt_unit == UNIT_LAST) begin
               unit_next = '0;
               dur_next  = dur_left - DUR_W'(1);
               if (dur_left == DUR_W'(1)) begin
                  state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                  gap_next   = '0;
               end
            end else begin
               unit_next = cnt_unit + UNIT_W'(1);
            end
         end
         GAP: begin
            if (cnt_gap == GAP_LAST) state_next = IDLE;
            else                     gap_next   = cnt_gap + GAP_W'(1);
         end
         default: state_next = IDLE;
      endcase

      if (do_grant) begin
         state_next  = PLAY;
         id_next     = grant_id;
         period_next = entry.period;
         dur_next    = (entry.dur == '0) ? DUR_W'(1) : entry.dur;
         unit_next   = '0;
      end

      sfx_grant    = do_grant ? (NUM_SFX'(1) << grant_id) : '0;
      pending_next = (pending & ~sfx_grant) | sfx_req;
   end

endmodule

// File: tb/tb_sfx_arbiter.sv
// Scoreboard bench for sfx_arbiter: a timestamp-based reference model queues
// expected per-cycle outputs and grants; a monitor pops and compares them.
module tb_sfx_arbiter;

   localparam int DUR_UNIT   = 4;
   localparam int GAP_CYCLES = 3;
   localparam int M_IDLE = 0;
   localparam int M_PLAY = 1;
   localparam int M_GAP  = 2;

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic [3:0] sfx_req    = '0;
   logic       music_beep = 1'b0;
   logic       music_en   = 1'b0;
   logic       beep, sfx_busy;
   logic [1:0] sfx_id;
   logic [3:0] sfx_grant;

   sfx_arbiter #(
      .DUR_UNIT   (DUR_UNIT),
      .GAP_CYCLES (GAP_CYCLES),
      .USE_SIM    (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sfx_req    (sfx_req),
      .music_beep (music_beep),
      .music_en   (music_en),
      .beep       (beep),
      .sfx_busy   (sfx_busy),
      .sfx_id     (sfx_id),
      .sfx_grant  (sfx_grant)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; logic beep; logic busy; logic [1:0] id; } cyc_exp_t;
   typedef struct { int cyc; logic [3:0] grant; } grant_exp_t;

   cyc_exp_t   cycQ[$];
   grant_exp_t grantQ[$];
   int nChecks = 0;
   int nFails  = 0;

   // Reference model: one effect at a time, described by absolute timestamps.
   int periodTbl [4] = '{8, 6, 10, 4};
   int durTbl    [4] = '{2, 1, 0, 1};
   logic [3:0] mPending = '0;
   bit  mActive  = 1'b0;
   int  mId      = 0;
   int  mStart   = 0;
   int  mPlayEnd = 0;
   int  mGapEnd  = 0;
   int  mPeriod  = 1;
   int  cyc      = 0;
   int  monCyc   = -1;

   function automatic int highestIdx(input logic [3:0] p);
      int h = -1;
      for (int i = 0; i < 4; i++) if (p[i]) h = i;
      return h;
   endfunction

   function automatic int modeAt(input int c);
      if (!mActive)     return M_IDLE;
      if (c < mPlayEnd) return M_PLAY;
      if (c < mGapEnd)  return M_GAP;
      return M_IDLE;
   endfunction

   function automatic logic [3:0] grantFor(input int c);
      int m = modeAt(c);
      int h = highestIdx(mPending);
      if (h < 0) return 4'b0000;
      if (m == M_IDLE || (m == M_PLAY && h > mId)) return 4'(1 << h);
      return 4'b0000;
   endfunction

   task automatic checkOutput(input string name, input int c,
                              input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, c, got, exp);
      end
   endtask

   // Drives one cycle of inputs and advances the model to the next cycle.
   task automatic applyStimulus(input logic [3:0] req, input logic r,
                                input logic mb, input logic en);
      logic [3:0] g;
      logic       bNext;
      int         m, h, d;
      @(negedge clk);
      sfx_req    = req;
      rst        = r;
      music_beep = mb;
      music_en   = en;
      m = modeAt(cyc);
      if (r) begin
         mPending = '0;
         mActive  = 1'b0;
         mId      = 0;
         bNext    = 1'b0;
      end else begin
         g = grantFor(cyc);
         if (m == M_PLAY)     bNext = (((cyc - mStart) % mPeriod) >= (mPeriod / 2));
         else if (m == M_GAP) bNext = 1'b0;
         else                 bNext = mb & en;
         if (g != 4'b0000) begin
            h        = highestIdx(mPending);
            d        = (durTbl[h] == 0) ? 1 : durTbl[h];
            mId      = h;
            mPeriod  = periodTbl[h];
            mActive  = 1'b1;
            mStart   = cyc + 1;
            mPlayEnd = mStart + d * DUR_UNIT;
            mGapEnd  = mPlayEnd + GAP_CYCLES;
         end
         mPending = (mPending & ~g) | req;
      end
      cyc++;
      cycQ.push_back('{cyc, bNext, (modeAt(cyc) != M_IDLE), 2'(mId)});
      g = grantFor(cyc);
      if (g != 4'b0000) grantQ.push_back('{cyc, g});
   endtask

   task automatic idleCycles(input int n, input logic en);
      for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, 1'($urandom_range(0, 1)), en);
   endtask

   // Monitor: compares DUT outputs of each cycle against queued expectations.
   initial begin : monitor
      cyc_exp_t   e;
      grant_exp_t ge;
      forever begin
         @(posedge clk);
         #1;
         monCyc++;
         if (cycQ.size() > 0) begin
            e = cycQ.pop_front();
            checkOutput("beep", e.cyc, 32'(beep), 32'(e.beep));
            checkOutput("sfx_busy", e.cyc, 32'(sfx_busy), 32'(e.busy));
            checkOutput("sfx_id", e.cyc, 32'(sfx_id), 32'(e.id));
         end
         if (sfx_grant !== 4'b0000) begin
            if (grantQ.size() == 0) begin
               checkOutput("unexpected_grant", monCyc, 32'(sfx_grant), 32'd0);
            end else begin
               ge = grantQ.pop_front();
               checkOutput("grant", monCyc, 32'(sfx_grant), 32'(ge.grant));
               checkOutput("grant_cycle", monCyc, 32'(monCyc), 32'(ge.cyc));
            end
         end else if (grantQ.size() > 0 && grantQ[0].cyc <= monCyc) begin
            ge = grantQ.pop_front();
            checkOutput("missed_grant", ge.cyc, 32'(sfx_grant), 32'(ge.grant));
         end
      end
   end

   initial begin : driver
      logic [3:0] rq;
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);

      idleCycles(10, 1'b1);

      applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1);
      idleCycles(16, 1'b1);

      applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
      idleCycles(3, 1'b1);
      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1);
      idleCycles(20, 1'b1);

      applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
      idleCycles(30, 1'b1);

      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1);
      idleCycles(2, 1'b1);
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1);
      idleCycles(20, 1'b0);

      applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
      idleCycles(35, 1'b1);

      for (int i = 0; i < 1500; i++) begin
         rq = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         applyStimulus(rq, ($urandom_range(0, 299) == 0),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      checkOutput("scoreboard_drained", cyc, 32'(cycQ.size() + grantQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/sfx_arbiter.md
SFX_ARBITER -- requirements
Module: sfx_arbiter

Interface
REQ-001 SHALL have parameter DUR_UNIT, default 50000: clock cycles per SFX duration unit.
REQ-002 SHALL have parameter GAP_CYCLES, default 1000: forced-silence cycles after each SFX.
REQ-003 SHALL have port clk  in  1: single clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst  in  1: synchronous active-high reset.
REQ-005 SHALL have port sfx_req  in  4: one-cycle request pulses; index 3 is the highest priority.
REQ-006 SHALL have port music_beep  in  1: square wave from the background music player.
REQ-007 SHALL have port music_en  in  1: gates music_beep while no SFX owns the buzzer.
REQ-008 SHALL have port beep  out  1: registered buzzer drive.
REQ-009 SHALL have port sfx_busy  out  1: high in PLAY or GAP.
REQ-010 SHALL have port sfx_id  out  2: id of the SFX currently or last playing.
REQ-011 SHALL have port sfx_grant  out  4: one-hot one-cycle pulse marking the start of a granted SFX.

Function
REQ-012 SHALL latch each sfx_req[i] pulse into pending[i] until granted; set wins over clear in the same cycle.
REQ-013 SHALL implement FSM states IDLE, PLAY, GAP.
REQ-014 IDLE: if any pending, SHALL grant the highest pending index, pulse sfx_grant, load period/duration from the table, clear cnt_tone/cnt_unit, and enter PLAY next cycle.
REQ-015 PLAY: cnt_tone SHALL count 0..period-1 and wrap; the SFX wave is 1 when cnt_tone >= period/2 (integer divide).
REQ-016 PLAY: cnt_unit SHALL count 0..DUR_UNIT-1; on each wrap dur_left decrements; the cycle dur_left reaches 0 SHALL transition to GAP.
REQ-017 A table duration of 0 SHALL be treated as 1 unit.
REQ-018 PLAY: a pending index strictly greater than sfx_id SHALL preempt: re-grant, reload, clear counters, stay in PLAY; equal or lower indices wait.
REQ-019 GAP: SHALL count GAP_CYCLES cycles, then enter IDLE; a grant can then occur on the IDLE cycle.
REQ-020 GAP_CYCLES = 0 SHALL skip GAP (PLAY -> IDLE directly).
REQ-021 beep SHALL be registered with 1-cycle latency: SFX wave in PLAY, 0 in GAP, music_beep & music_en in IDLE.
REQ-022 A re-request of the playing id SHALL set pending and replay after GAP, with no restart.

Reset
REQ-023 On rst, SHALL reset to: state IDLE, pending 0, all counters 0, beep 0, sfx_busy 0, sfx_id 0, sfx_grant 0.
REQ-024 rst mid-PLAY or mid-GAP SHALL abort immediately; pre-reset requests are lost.

Structure
REQ-025 The shared package SHALL hold the state enum, SFX id width, and the 4-entry table: 17-bit period (clock cycles) and 8-bit duration units per id.
REQ-026 The square-wave tone counter SHALL be a sub-module, sfx_tone_gen (period in, enable/clear in, wave out).
REQ-027 The package table SHALL be overridable for simulation via a package-level constant.

Verification (DUR_UNIT=4, GAP_CYCLES=3; table id0 period 8 dur 2, id3 period 4 dur 1)
REQ-028 SHALL cover: music_en=1, no requests -> beep follows music_beep with 1-cycle delay.
REQ-029 SHALL cover: sfx_req=0001 at cycle 10 -> grant 0001 at cycle 11; PLAY 8 cycles; beep 0,0,0,0,1,1,1,1 repeated; GAP 3 cycles with beep 0; IDLE at cycle 23.
REQ-030 SHALL cover: id0 playing, sfx_req=1000 -> grant 1000 next cycle; sfx_id=3; 4 cycles of period-4 wave, then GAP; id0 is not resumed.
REQ-031 SHALL cover: sfx_req=0011 in the same cycle -> id1 granted first; id0 granted on the IDLE cycle after id1's GAP.
REQ-032 SHALL cover: rst pulsed mid-PLAY with id2 pending -> all outputs 0 next cycle, pending cleared, no later grant.
REQ-033 SHALL cover: sfx_req[0] on the grant cycle of id0 -> id0 plays twice, separated by GAP.
